// File: rtl/ddr3_app_requester.sv
// Initiator for the MIG 7-series DDR3 app_* interface: sequences single-beat
// read/write commands and buffers read returns in a credit-limited FWFT FIFO.
module ddr3_app_requester #(
  parameter int unsigned ADDR_WIDTH    = 30,
  parameter int unsigned DATA_WIDTH    = 512,
  parameter int unsigned MASK_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned RD_FIFO_DEPTH = 8
) (
  input  logic                               ui_clk,
  input  logic                               ui_rst_n,
  input  logic                               init_calib_complete,
  // client request channel
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic                               req_write,
  input  logic [ADDR_WIDTH-1:0]              req_addr,
  input  logic [DATA_WIDTH-1:0]              req_wdata,
  input  logic [MASK_WIDTH-1:0]              req_mask,
  // client response channel
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [DATA_WIDTH-1:0]              rsp_data,
  // controller app interface
  output logic [ADDR_WIDTH-1:0]              app_addr,
  output logic [2:0]                         app_cmd,
  output logic                               app_en,
  input  logic                               app_rdy,
  output logic [DATA_WIDTH-1:0]              app_wdf_data,
  output logic [MASK_WIDTH-1:0]              app_wdf_mask,
  output logic                               app_wdf_wren,
  output logic                               app_wdf_end,
  input  logic                               app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0]              app_rd_data,
  input  logic                               app_rd_data_valid,
  // status
  output logic [$clog2(RD_FIFO_DEPTH):0]     rd_outstanding,
  output logic                               rd_overflow
);

  localparam int unsigned PTR_W = $clog2(RD_FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [2:0]  CMD_WRITE = 3'b000;
  localparam logic [2:0]  CMD_READ  = 3'b001;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [MASK_WIDTH-1:0] r_mask;
  logic                  r_cmd_done;
  logic                  r_data_done;

  logic [CNT_W-1:0]      r_credits;
  logic [DATA_WIDTH-1:0] r_mem [RD_FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_rd_overflow;

  logic w_req_fire;
  logic w_cmd_fire;
  logic w_dat_fire;
  logic w_rd_issue;
  logic w_pop;
  logic w_push;
  logic w_full;

  assign w_req_fire = req_valid && req_ready;
  assign w_cmd_fire = app_en && app_rdy;
  assign w_dat_fire = app_wdf_wren && app_wdf_rdy;
  assign w_rd_issue = w_cmd_fire && !r_write;
  assign w_full     = (r_count == CNT_W'(RD_FIFO_DEPTH));
  assign w_pop      = rsp_valid && rsp_ready;
  // A beat arriving at full is still accepted when the head leaves this cycle.
  assign w_push     = app_rd_data_valid && (!w_full || w_pop);

  // State register
  always_ff @(posedge ui_clk or negedge ui_rst_n) begin
    if (!ui_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: return to IDLE once both handshakes are (or become) done
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req_fire) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if ((r_cmd_done || w_cmd_fire) && (r_data_done || w_dat_fire)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: strobes derive only from registered state and calibration
  always_comb begin
    req_ready    = 1'b0;
    app_en       = 1'b0;
    app_wdf_wren = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = init_calib_complete && (r_credits != '0);
      end
      S_ISSUE: begin
        app_en       = !r_cmd_done;
        app_wdf_wren = !r_data_done;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  assign app_wdf_end  = app_wdf_wren;
  assign app_cmd      = r_write ? CMD_WRITE : CMD_READ;
  assign app_addr     = r_addr;
  assign app_wdf_data = r_wdata;
  assign app_wdf_mask = r_mask;

  // Request holding registers and per-transaction handshake tracking
  always_ff @(posedge ui_clk or negedge ui_rst_n) begin
    if (!ui_rst_n) begin
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_mask      <= '0;
      r_cmd_done  <= 1'b0;
      r_data_done <= 1'b0;
    end else if (w_req_fire) begin
      r_addr      <= req_addr;
      r_write     <= req_write;
      r_wdata     <= req_wdata;
      r_mask      <= req_mask;
      r_cmd_done  <= 1'b0;
      r_data_done <= !req_write;
    end else begin
      if (w_cmd_fire) begin
        r_cmd_done <= 1'b1;
      end
      if (w_dat_fire) begin
        r_data_done <= 1'b1;
      end
    end
  end

  // Read credits: one per FIFO slot, spent at command issue, returned at pop
  always_ff @(posedge ui_clk or negedge ui_rst_n) begin
    if (!ui_rst_n) begin
      r_credits <= CNT_W'(RD_FIFO_DEPTH);
    end else begin
      case ({w_rd_issue, w_pop})
        2'b10:   r_credits <= r_credits - CNT_W'(1);
        2'b01:   r_credits <= r_credits + CNT_W'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  assign rd_outstanding = CNT_W'(RD_FIFO_DEPTH) - r_credits;

  // Read-return FIFO storage; contents are qualified by r_count so no reset
  always_ff @(posedge ui_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= app_rd_data;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge ui_clk or negedge ui_rst_n) begin
    if (!ui_rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_rd_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (app_rd_data_valid && w_full && !w_pop) begin
        r_rd_overflow <= 1'b1;
      end
    end
  end

  assign rsp_valid   = (r_count != '0);
  assign rsp_data    = r_mem[r_rd_ptr];
  assign rd_overflow = r_rd_overflow;

endmodule

// File: tb/tb_ddr3_app_requester.sv
// Randomized bench for ddr3_app_requester: a transaction-level model of the
// client/controller contract is checked every cycle, plus directed corner cases.
module tb_ddr3_app_requester;

  localparam int unsigned AW    = 30;
  localparam int unsigned DW    = 512;
  localparam int unsigned MW    = DW / 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          ui_clk = 1'b0;
  logic          ui_rst_n;
  logic          calib;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [MW-1:0] req_mask;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en, app_rdy;
  logic [DW-1:0] app_wdf_data;
  logic [MW-1:0] app_wdf_mask;
  logic          app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid;
  logic [CW-1:0] rd_outstanding;
  logic          rd_overflow;

  always #5 ui_clk = ~ui_clk;

  ddr3_app_requester #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .RD_FIFO_DEPTH(DEPTH)
  ) dut (
    .ui_clk(ui_clk), .ui_rst_n(ui_rst_n), .init_calib_complete(calib),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .rd_outstanding(rd_outstanding), .rd_overflow(rd_overflow)
  );

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] mask;
  } req_t;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: one transaction in flight, FIFO contents, controller return queue
  bit            m_busy, m_cmd_pend, m_data_pend, m_ovf;
  req_t          m_cur;
  int            m_out;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] ret_q[$];

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] rd_pat(input logic [AW-1:0] a);
    logic [DW-1:0] p;
    for (int i = 0; i < int'(DW / 32); i++) p[i*32 +: 32] = (32'(a) * 32'h9E37_79B1) + 32'(i);
    return p;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < int'(DW / 32); i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_cmd_pend = 0; m_data_pend = 0; m_ovf = 0; m_out = 0;
    fifo_q.delete();
    ret_q.delete();
  endtask

  // Called with inputs settled mid-cycle: check outputs, predict handshakes, advance one clock
  task automatic cyc();
    logic exp_ready;
    bit   cmd_fire, dat_fire, pop, full;
    exp_ready = !m_busy && calib && (m_out < int'(DEPTH));
    chk("req_ready", DW'(req_ready), DW'(exp_ready));
    chk("app_en", DW'(app_en), DW'(m_busy && m_cmd_pend));
    chk("app_wdf_wren", DW'(app_wdf_wren), DW'(m_busy && m_data_pend));
    chk("app_wdf_end", DW'(app_wdf_end), DW'(m_busy && m_data_pend));
    if (m_busy) begin
      chk("app_addr", DW'(app_addr), DW'(m_cur.addr));
      chk("app_cmd", DW'(app_cmd), DW'(m_cur.write ? 3'b000 : 3'b001));
      if (m_data_pend) begin
        chk("app_wdf_data", app_wdf_data, m_cur.wdata);
        chk("app_wdf_mask", DW'(app_wdf_mask), DW'(m_cur.mask));
      end
    end
    chk("rsp_valid", DW'(rsp_valid), DW'(fifo_q.size() != 0));
    if (fifo_q.size() != 0) chk("rsp_data", rsp_data, fifo_q[0]);
    chk("rd_outstanding", DW'(rd_outstanding), DW'(m_out));
    chk("rd_overflow", DW'(rd_overflow), DW'(m_ovf));

    cmd_fire = m_busy && m_cmd_pend && app_rdy;
    dat_fire = m_busy && m_data_pend && app_wdf_rdy;
    pop      = (fifo_q.size() != 0) && rsp_ready;
    full     = (fifo_q.size() == int'(DEPTH));
    if (app_rd_data_valid) begin
      if (!full || pop) fifo_q.push_back(app_rd_data);
      else m_ovf = 1;
    end
    if (pop) begin
      void'(fifo_q.pop_front());
      m_out--;
    end
    if (cmd_fire) begin
      m_cmd_pend = 0;
      if (!m_cur.write) begin
        m_out++;
        ret_q.push_back(rd_pat(m_cur.addr));
      end
    end
    if (dat_fire) m_data_pend = 0;
    if (m_busy && !m_cmd_pend && !m_data_pend) m_busy = 0;
    else if (!m_busy && req_valid && exp_ready) begin
      m_busy      = 1;
      m_cmd_pend  = 1;
      m_data_pend = req_write;
      m_cur       = '{req_write, req_addr, req_wdata, req_mask};
    end
    @(posedge ui_clk);
    #1;
  endtask

  // Issue reads until every credit is spent, then return every beat unpopped
  task automatic fill_fifo();
    rsp_ready = 0; app_rdy = 1; app_wdf_rdy = 1; calib = 1;
    for (int t = 0; t < 40 && m_out < int'(DEPTH); t++) begin
      req_valid = 1; req_write = 0; req_addr = AW'($urandom);
      #1; cyc();
    end
    req_valid = 0;
    for (int t = 0; t < 20 && ret_q.size() != 0; t++) begin
      app_rd_data = ret_q.pop_front(); app_rd_data_valid = 1;
      #1; cyc();
    end
    app_rd_data_valid = 0;
  endtask

  task automatic drive_rand(input int phase);
    calib       = ($urandom_range(0, 19) != 0);
    req_valid   = $urandom_range(0, 1) == 1;
    req_write   = $urandom_range(0, 1) == 1;
    req_addr    = AW'($urandom);
    req_wdata   = rand_data();
    req_mask    = {$urandom, $urandom};
    rsp_ready   = (phase % 2 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
    app_rdy     = $urandom_range(0, 2) != 0;
    app_wdf_rdy = $urandom_range(0, 2) != 0;
    if (ret_q.size() != 0 && $urandom_range(0, 1) == 1) begin
      app_rd_data = ret_q.pop_front(); app_rd_data_valid = 1;
    end else begin
      app_rd_data = rand_data(); app_rd_data_valid = 0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ui_rst_n = 0; calib = 0; req_valid = 0; req_write = 0; req_addr = '0;
    req_wdata = '0; req_mask = '0; rsp_ready = 0; app_rdy = 0; app_wdf_rdy = 0;
    app_rd_data = '0; app_rd_data_valid = 0;
    model_reset();
    @(posedge ui_clk); #1;
    chk("rst_app_en", DW'(app_en), '0);
    chk("rst_wren", DW'(app_wdf_wren), '0);
    chk("rst_req_ready", DW'(req_ready), '0);
    chk("rst_rsp_valid", DW'(rsp_valid), '0);
    chk("rst_outstanding", DW'(rd_outstanding), '0);
    chk("rst_overflow", DW'(rd_overflow), '0);
    chk("rst_addr", DW'(app_addr), '0);
    chk("rst_wdata", app_wdf_data, '0);
    @(posedge ui_clk); #1;
    ui_rst_n = 1; calib = 1;

    // Back-to-back single-cycle write
    req_valid = 1; req_write = 1; req_addr = AW'('h100); req_wdata = {64{8'hA5}}; req_mask = '0;
    app_rdy = 1; app_wdf_rdy = 1;
    #1; chk("t1_ready_n", DW'(req_ready), DW'(1)); cyc();
    req_valid = 0;
    #1;
    chk("t1_en_n1", DW'(app_en), DW'(1));
    chk("t1_wren_n1", DW'(app_wdf_wren), DW'(1));
    chk("t1_cmd_n1", DW'(app_cmd), DW'(3'b000));
    chk("t1_addr_n1", DW'(app_addr), DW'('h100));
    cyc();
    #1; chk("t1_en_n2", DW'(app_en), '0); chk("t1_ready_n2", DW'(req_ready), DW'(1)); cyc();

    // Write with command stalled for three cycles
    req_valid = 1; req_write = 1; req_addr = AW'('h2A0); req_wdata = rand_data(); app_rdy = 0;
    #1; cyc();
    req_valid = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t2_en_stall", DW'(app_en), DW'(1));
      chk("t2_wren", DW'(app_wdf_wren), DW'(k == 0));
      chk("t2_addr_stable", DW'(app_addr), DW'('h2A0));
      cyc();
    end
    app_rdy = 1;
    #1; chk("t2_en_hs", DW'(app_en), DW'(1)); chk("t2_busy", DW'(req_ready), '0); cyc();
    #1; chk("t2_ready_back", DW'(req_ready), DW'(1)); chk("t2_en_drop", DW'(app_en), '0); cyc();

    // Credit exhaustion, in-order return and credit release on pop
    fill_fifo();
    req_valid = 1; req_write = 0;
    #1;
    chk("t3_outstanding_full", DW'(rd_outstanding), DW'(DEPTH));
    chk("t3_ready_blocked", DW'(req_ready), '0);
    chk("t3_rsp_valid", DW'(rsp_valid), DW'(1));
    cyc();
    req_valid = 0; rsp_ready = 1;
    #1; cyc();
    rsp_ready = 0;
    #1; chk("t3_ready_after_pop", DW'(req_ready), DW'(1)); cyc();
    rsp_ready = 1;
    for (int k = 0; k < int'(DEPTH) - 1; k++) begin
      #1; chk("t3_pop_valid", DW'(rsp_valid), DW'(1)); cyc();
    end
    #1; chk("t3_drained", DW'(rsp_valid), '0); cyc();
    rsp_ready = 0;

    // Calibration gating; a drop mid-transaction does not abort it
    calib = 0; req_valid = 1; req_write = 1; req_addr = AW'($urandom); req_wdata = rand_data();
    for (int k = 0; k < 3; k++) begin
      #1; chk("t5_ready_nocal", DW'(req_ready), '0); cyc();
    end
    calib = 1;
    #1; chk("t5_ready_cal", DW'(req_ready), DW'(1)); cyc();
    req_valid = 0; calib = 0; app_rdy = 0; app_wdf_rdy = 0;
    #1; chk("t5_en_nocal", DW'(app_en), DW'(1)); cyc();
    app_rdy = 1; app_wdf_rdy = 1;
    #1; chk("t5_en_hold", DW'(app_en), DW'(1)); chk("t5_wren_hold", DW'(app_wdf_wren), DW'(1)); cyc();
    #1; chk("t5_done", DW'(app_en), '0); chk("t5_idle_nocal", DW'(req_ready), '0); cyc();
    calib = 1;

    // Reset during ISSUE with a read beat queued
    req_valid = 1; req_write = 0; req_addr = AW'($urandom);
    #1; cyc();
    req_valid = 0;
    #1; cyc();
    app_rd_data = ret_q.pop_front(); app_rd_data_valid = 1;
    #1; cyc();
    app_rd_data_valid = 0;
    req_valid = 1; req_write = 1; req_addr = AW'($urandom); app_rdy = 0; app_wdf_rdy = 0;
    #1; cyc();
    req_valid = 0;
    #1; chk("t6_en_pre", DW'(app_en), DW'(1)); cyc();
    ui_rst_n = 0;
    #1;
    chk("t6_en_rst", DW'(app_en), '0);
    chk("t6_wren_rst", DW'(app_wdf_wren), '0);
    chk("t6_rsp_valid_rst", DW'(rsp_valid), '0);
    chk("t6_outstanding_rst", DW'(rd_outstanding), '0);
    model_reset();
    @(posedge ui_clk); #1;
    ui_rst_n = 1; app_rdy = 1; app_wdf_rdy = 1;
    #1; cyc();

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      drive_rand(i / 200);
      #1; cyc();
    end

    req_valid = 0; rsp_ready = 1; app_rdy = 1; app_wdf_rdy = 1; calib = 1;
    for (int t = 0; t < 100 && (m_busy || ret_q.size() != 0 || fifo_q.size() != 0); t++) begin
      if (ret_q.size() != 0) begin
        app_rd_data = ret_q.pop_front(); app_rd_data_valid = 1;
      end else app_rd_data_valid = 0;
      #1; cyc();
    end
    app_rd_data_valid = 0;
    #1;
    chk("drain_outstanding", DW'(rd_outstanding), '0);
    chk("drain_rsp_valid", DW'(rsp_valid), '0);
    cyc();

    // Full FIFO: push with simultaneous pop is lossless; push without pop overflows
    fill_fifo();
    app_rd_data = rand_data(); app_rd_data_valid = 1; rsp_ready = 1;
    #1; cyc();
    rsp_ready = 0; app_rd_data = rand_data();
    #1; chk("t4_no_ovf", DW'(rd_overflow), '0); cyc();
    app_rd_data_valid = 0;
    #1; chk("t4_ovf_set", DW'(rd_overflow), DW'(1)); cyc();
    rsp_ready = 1;
    for (int k = 0; k < 3; k++) begin
      #1; cyc();
    end
    rsp_ready = 0;
    #1; chk("t4_ovf_sticky", DW'(rd_overflow), DW'(1)); cyc();
    ui_rst_n = 0;
    #1; chk("t4_ovf_rst", DW'(rd_overflow), '0);
    model_reset();
    @(posedge ui_clk); #1;
    ui_rst_n = 1;
    #1; cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ddr3_app_requester.md
Name: ddr3_app_requester

Overview:
- Initiator-side driver for the MIG 7-series DDR3 user (app_*) interface, clocked in the controller's ui_clk domain.
- Accepts single-beat read/write requests from a client valid/ready channel and sequences app_en/app_wdf_wren against app_rdy/app_wdf_rdy.
- Buffers returning read data in a FIFO, because the controller provides no read-data backpressure; outstanding reads are credit-limited so that FIFO can never overflow.

Parameters:
- ADDR_WIDTH, 30, app_addr width.
- DATA_WIDTH, 512, app_wdf_data/app_rd_data width (nCK_PER_CLK*2*PAYLOAD_WIDTH).
- MASK_WIDTH, DATA_WIDTH/8, byte-mask width.
- RD_FIFO_DEPTH, 8, read-return FIFO entries; also the maximum outstanding reads; power of 2, at least 2.

Ports:
- ui_clk  in  1  sole clock (controller UI clock).
- ui_rst_n  in  1  asynchronous, active-low reset.
- init_calib_complete  in  1  controller calibration done.
- req_valid  in  1  client request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  request address.
- req_wdata  in  DATA_WIDTH  write data.
- req_mask  in  MASK_WIDTH  write byte mask; 1 = byte not written.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  client consumes read data.
- rsp_data  out  DATA_WIDTH  read data.
- app_addr  out  ADDR_WIDTH  to controller.
- app_cmd  out  3  3'b000 = write, 3'b001 = read.
- app_en  out  1  command valid.
- app_rdy  in  1  command accepted.
- app_wdf_data  out  DATA_WIDTH  write data.
- app_wdf_mask  out  MASK_WIDTH  write mask.
- app_wdf_wren  out  1  write data valid.
- app_wdf_end  out  1  equals app_wdf_wren (single beat per burst).
- app_wdf_rdy  in  1  write data accepted.
- app_rd_data  in  DATA_WIDTH  returning read data.
- app_rd_data_valid  in  1  read data valid.
- rd_outstanding  out  $clog2(RD_FIFO_DEPTH)+1  reads issued whose data is not yet popped by the client.
- rd_overflow  out  1  sticky error flag.

Behaviour:
- Reset (async assert, synchronous deassert handled upstream):
  - State is IDLE.
  - app_en, app_wdf_wren, app_wdf_end, req_ready, rsp_valid and rd_overflow are 0.
  - Read credits = RD_FIFO_DEPTH; rd_outstanding = 0; FIFO empty.
  - Address, data and mask holding registers reset to 0.
- req_ready = (state == IDLE) && init_calib_complete && (credits != 0). It is registered-state based only, with no combinational path from req_valid.
- Acceptance in cycle N:
  - Latch addr, write, wdata and mask.
  - Clear cmd_done and data_done; set data_done = 1 for a read.
  - Move to ISSUE. app_en is high in cycle N+1.
- ISSUE state:
  - app_en = !cmd_done.
  - app_wdf_wren = !data_done.
  - app_cmd reflects the latched type.
  - Command handshake completes on app_en && app_rdy; this sets cmd_done.
  - Data handshake completes on app_wdf_wren && app_wdf_rdy; this sets data_done.
  - The two handshakes are independent and may complete in the same cycle or in either order.
  - Once both are done (including via handshakes completing this cycle), state returns to IDLE next cycle.
  - Outputs hold stable while waiting; app_en and app_wdf_wren never drop before their handshake.
- Credits:
  - Decrement on a read command handshake.
  - Increment on a FIFO pop.
  - A simultaneous decrement and increment leaves credits unchanged.
  - rd_outstanding = RD_FIFO_DEPTH - credits.
- Read FIFO (first-word fall-through):
  - Push on app_rd_data_valid.
  - Pop on rsp_valid && rsp_ready.
  - rsp_valid = !empty; rsp_data = head entry.
  - Push and pop in the same cycle are allowed at any occupancy, including full.
  - Read-pointer and write-pointer wrap modulo RD_FIFO_DEPTH.
  - The controller runs in strict-order mode, so data returns in issue order.
- Overflow: app_rd_data_valid while the FIFO is full and not popping drops the data and sets rd_overflow. rd_overflow clears only on reset. This condition is unreachable by design and is flagged for verification.
- Calibration: init_calib_complete falling mid-transaction does not abort the transaction; ISSUE completes. No new request is accepted until calibration is complete again.
- Reset mid-transaction: all state is cleared immediately. In-flight read data arriving after reset deasserts is pushed normally.
- Throughput: at most one request per 2 cycles (accept in IDLE, issue in ISSUE).

Test Plan:
- Write A=0x100, data=0xA5 pattern, mask=0, with app_rdy=app_wdf_rdy=1 → app_en and app_wdf_wren both high for exactly 1 cycle at N+1, app_cmd=000; req_ready high again at N+2.
- Write with app_rdy held low for 3 cycles and app_wdf_rdy high → wren handshakes in cycle N+1 and drops; app_en stays high 4 cycles with stable addr; req_ready returns 1 cycle after the app_rdy handshake.
- 8 reads issued with rsp_ready=0 → rd_outstanding reaches 8 and req_ready=0; return 8 beats → 8 entries queued; pop 1 → req_ready=1 next cycle; data popped in issue order.
- FIFO full with a simultaneous app_rd_data_valid and pop → no loss, rd_overflow stays 0; forced extra valid while full with no pop → rd_overflow=1 and sticky.
- init_calib_complete=0 with req_valid=1 → req_ready=0, no app_en; calibration raised → accepted next cycle. Calibration dropped during ISSUE → handshake still completes.
- ui_rst_n asserted during ISSUE → app_en/app_wdf_wren go 0 asynchronously, credits return to 8, rsp_valid=0.
